specinvert_core: RTL and testbench
==================================

Name: specinvert_core

Overview:
User-logic core for the specinvert RFNoC block. It is the consuming end of the NoC shell's client interface:
- CtrlPort responder (register file) for the shell's CtrlPort master.
- AXIS sink for the shell's "in" stream and AXIS source for its "out" stream.
- Conjugates (and optionally swaps I/Q of) sc16 samples, one item per beat, with sideband passed through.

Parameters:
COMPAT_NUM, 32'h0001_0000, value returned by REG_COMPAT.
ITEM_W, 32, item width; only 32 (sc16: I=[31:16], Q=[15:0]) is supported.

Ports:
ce_clk  in  1  core clock; CtrlPort and AXIS share it.
ce_rst  in  1  reset, asynchronous, active-high.
s_ctrlport_req_wr  in  1  write request pulse.
s_ctrlport_req_rd  in  1  read request pulse.
s_ctrlport_req_addr  in  20  byte address.
s_ctrlport_req_data  in  32  write data.
s_ctrlport_resp_ack  out  1  response pulse.
s_ctrlport_resp_data  out  32  read data, valid with ack.
s_in_axis_tdata/tkeep/tlast/tvalid/tready  in,in,in,in,out  32/1/1/1/1  input sample stream.
s_in_axis_ttimestamp/thas_time/tlength/teov/teob  in  64/1/16/1/1  input sideband.
m_out_axis_tdata/tkeep/tlast/tvalid/tready  out,out,out,out,in  32/1/1/1/1  output sample stream.
m_out_axis_ttimestamp/thas_time/tlength/teov/teob  out  64/1/16/1/1  output sideband.

Behaviour:
- Reset values: resp_ack=0, resp_data=0, m_out_axis_tvalid=0, all other m_out outputs 0, REG_CTRL=0, pkt_cnt=0, sop=1.
- Registers, decoded on addr[7:0]; addr[19:8] ignored:
  - 0x00 REG_COMPAT: RO, returns COMPAT_NUM.
  - 0x04 REG_CTRL: RW. bit0 invert_en, bit1 swap_iq; other bits read 0.
  - 0x08 REG_PKT_CNT: RO count of output packets. Any write clears it.
  - Unmapped addresses: reads return 0, writes are ignored; ack is still given.
- CtrlPort timing:
  - resp_ack is exactly one cycle after req_wr or req_rd, and lasts one cycle.
  - resp_data is 0 on write acks.
  - wr and rd asserted together: one ack; data is the pre-write value; the write takes effect.
- Datapath: one register stage, full throughput.
  - s_in_axis_tready = !m_out_axis_tvalid || m_out_axis_tready.
  - Latency 1 cycle. tvalid holds until tready; data and sideband stay stable while stalled.
- Config latching:
  - active_cfg is loaded from REG_CTRL on the accepted beat with sop=1, and also applies to that beat.
  - sop is set after an accepted tlast beat and cleared after an accepted non-tlast beat.
  - A REG_CTRL write mid-packet affects the next packet only.
- Arithmetic, per beat:
  - Inputs are I=d[31:16], Q=d[15:0].
  - invert_en=1: Q' = sat(-Q), so -32768 becomes 32767; I unchanged.
  - swap_iq=1: output {Q',I}; otherwise {I,Q'}.
  - Both bits 0: exact passthrough.
- Sideband (ttimestamp, thas_time, tlength, teov, teob, tkeep, tlast) is registered with the data on every accepted beat.
- pkt_cnt:
  - Increments on an output handshake with tlast=1; 32-bit wrap, FFFF_FFFF becomes 0.
  - A clear in the same cycle as an increment wins: result is 0.
- Reset mid-packet: output valid drops asynchronously, and the first beat after reset is treated as sop.

Decomposition:
- Package specinvert_regs_pkg:
  - Address localparams REG_COMPAT_ADDR, REG_CTRL_ADDR, REG_PKT_CNT_ADDR.
  - CTRL bit indices.
  - Packed struct ctrl_t {swap_iq, invert_en}.
  - Function sat_neg16.
- One sub-module, specinvert_regs: CtrlPort decode, REG_CTRL, pkt_cnt, ack logic.
- Datapath stays in the top module.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08: acks one cycle after each rd, data 0x0001_0000, 0, 0. Read 0x40: data 0, ack given.
- Write 0x04=1, send 8-beat packet of 0x1234_5678 with ts=0x100, has_time=1, eob on last beat: every output beat is 0x1234_A988 one cycle after input; sideband matches input.
- Invert_en=1 with Q=0x8000 and Q=0x0000: outputs Q=0x7FFF and 0x0000. Write 0x04=3 with input 0x1111_0002: output 0xFFFE_1111.
- Write 0x04=1 on beat 3 of 6 while previously 0: whole packet passes unmodified; next packet is inverted.
- Random tready (50%) over 100 packets: no data loss or duplication; REG_PKT_CNT reads 100. Write 0x08 coinciding with a tlast handshake: reads 0.
- Assert ce_rst with m_out_axis_tvalid high and a packet in flight: tvalid goes 0 immediately, registers read 0, and the next packet is latched as sop.

Source files
------------

// File: rtl/specinvert_regs_pkg.sv
// Purpose  : shared register map, control-field layout and sample helpers for specinvert.
// Latency  : n/a (package only).
// Backpress: n/a (package only).
package specinvert_regs_pkg;

    // Register byte offsets, decoded on addr[7:0] only.
    localparam logic [7:0] REG_COMPAT_ADDR  = 8'h00;
    localparam logic [7:0] REG_CTRL_ADDR    = 8'h04;
    localparam logic [7:0] REG_PKT_CNT_ADDR = 8'h08;

    // Bit positions inside REG_CTRL.
    localparam int CTRL_INVERT_BIT = 0;
    localparam int CTRL_SWAP_BIT   = 1;

    // Packed so that invert_en lands on bit 0 and swap_iq on bit 1,
    // matching the REG_CTRL layout for direct readback.
    typedef struct packed {
        logic swap_iq;
        logic invert_en;
    } ctrl_t;

    // Saturating two's-complement negate: -(-32768) has no 16-bit
    // representation, so it clips to +32767 instead of wrapping to itself.
    function automatic logic [15:0] sat_neg16(input logic [15:0] q);
        logic [15:0] res;
        if (q == 16'h8000) begin
            res = 16'h7FFF;
        end else begin
            res = (~q) + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/specinvert_regs.sv
// Purpose  : CtrlPort responder holding REG_CTRL and the output packet counter.
// Latency  : ack and read data one cycle after a wr/rd request, for one cycle.
// Backpress: none; every request is acknowledged, the port never stalls.
//
// Ports:
//   ce_clk, ce_rst            core clock, async active-high reset
//   req_wr/req_rd/req_addr/req_data   CtrlPort request from the shell
//   resp_ack/resp_data        CtrlPort response
//   pkt_done                  output-side handshake of a tlast beat
//   ctrl                      current REG_CTRL contents
module specinvert_regs
    import specinvert_regs_pkg::*;
#(
    parameter logic [31:0] COMPAT_NUM = 32'h0001_0000
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        req_wr,
    input  logic        req_rd,
    input  logic [19:0] req_addr,
    input  logic [31:0] req_data,
    output logic        resp_ack,
    output logic [31:0] resp_data,
    input  logic        pkt_done,
    output ctrl_t       ctrl
);

    logic [31:0] pkt_cnt;
    logic [31:0] rd_mux;
    logic [7:0]  reg_addr;
    logic        unused_bits;

    assign reg_addr    = req_addr[7:0];
    // Upper address bits are aliases and upper write-data bits have no home.
    assign unused_bits = ^{req_addr[19:8], req_data[31:2]};

    // Read mux works on the pre-write state, so a combined wr+rd returns
    // the old value while the write still lands.
    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_COMPAT_ADDR:  rd_mux = COMPAT_NUM;
            REG_CTRL_ADDR:    rd_mux = {30'd0, ctrl};
            REG_PKT_CNT_ADDR: rd_mux = pkt_cnt;
            default:          rd_mux = '0;
        endcase
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            resp_ack  <= 1'b0;
            resp_data <= '0;
            ctrl      <= '0;
            pkt_cnt   <= '0;
        end else begin
            resp_ack  <= req_wr | req_rd;
            resp_data <= req_rd ? rd_mux : 32'd0;

            if (req_wr && (reg_addr == REG_CTRL_ADDR)) begin
                ctrl.invert_en <= req_data[CTRL_INVERT_BIT];
                ctrl.swap_iq   <= req_data[CTRL_SWAP_BIT];
            end

            // Clear beats a concurrent increment.
            if (req_wr && (reg_addr == REG_PKT_CNT_ADDR)) begin
                pkt_cnt <= '0;
            end else if (pkt_done) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/specinvert_core.sv
// Purpose  : sc16 conjugate / I-Q swap core with CtrlPort registers, sideband passthrough.
// Latency  : 1 cycle input beat to output beat; ctrl responses 1 cycle.
// Backpress: single output register; in tready = !out tvalid || out tready (full rate).
//
// Ports:
//   ce_clk, ce_rst                     core clock, async active-high reset
//   s_ctrlport_*                       CtrlPort responder
//   s_in_axis_*                        input sample stream + sideband
//   m_out_axis_*                       output sample stream + sideband
module specinvert_core
    import specinvert_regs_pkg::*;
#(
    parameter logic [31:0] COMPAT_NUM = 32'h0001_0000,
    parameter int          ITEM_W     = 32
) (
    input  logic              ce_clk,
    input  logic              ce_rst,
    input  logic              s_ctrlport_req_wr,
    input  logic              s_ctrlport_req_rd,
    input  logic [19:0]       s_ctrlport_req_addr,
    input  logic [31:0]       s_ctrlport_req_data,
    output logic              s_ctrlport_resp_ack,
    output logic [31:0]       s_ctrlport_resp_data,
    input  logic [ITEM_W-1:0] s_in_axis_tdata,
    input  logic              s_in_axis_tkeep,
    input  logic              s_in_axis_tlast,
    input  logic              s_in_axis_tvalid,
    output logic              s_in_axis_tready,
    input  logic [63:0]       s_in_axis_ttimestamp,
    input  logic              s_in_axis_thas_time,
    input  logic [15:0]       s_in_axis_tlength,
    input  logic              s_in_axis_teov,
    input  logic              s_in_axis_teob,
    output logic [ITEM_W-1:0] m_out_axis_tdata,
    output logic              m_out_axis_tkeep,
    output logic              m_out_axis_tlast,
    output logic              m_out_axis_tvalid,
    input  logic              m_out_axis_tready,
    output logic [63:0]       m_out_axis_ttimestamp,
    output logic              m_out_axis_thas_time,
    output logic [15:0]       m_out_axis_tlength,
    output logic              m_out_axis_teov,
    output logic              m_out_axis_teob
);

    // sc16 only: I in the upper half, Q in the lower half.
    localparam int HALF_W = ITEM_W / 2;

    ctrl_t             reg_ctrl;
    ctrl_t             active_cfg;
    ctrl_t             beat_cfg;
    logic              sop;
    logic              in_acc;
    logic              pkt_done;
    logic [HALF_W-1:0] i_val;
    logic [HALF_W-1:0] q_val;
    logic [HALF_W-1:0] q_new;
    logic [ITEM_W-1:0] dat_new;

    specinvert_regs #(
        .COMPAT_NUM (COMPAT_NUM)
    ) u_regs (
        .ce_clk    (ce_clk),
        .ce_rst    (ce_rst),
        .req_wr    (s_ctrlport_req_wr),
        .req_rd    (s_ctrlport_req_rd),
        .req_addr  (s_ctrlport_req_addr),
        .req_data  (s_ctrlport_req_data),
        .resp_ack  (s_ctrlport_resp_ack),
        .resp_data (s_ctrlport_resp_data),
        .pkt_done  (pkt_done),
        .ctrl      (reg_ctrl)
    );

    assign s_in_axis_tready = !m_out_axis_tvalid || m_out_axis_tready;
    assign in_acc           = s_in_axis_tvalid && s_in_axis_tready;
    assign pkt_done         = m_out_axis_tvalid && m_out_axis_tready && m_out_axis_tlast;

    // The first beat of a packet uses REG_CTRL directly, so the config it
    // latches also governs that beat; later beats use the latched copy and
    // ignore mid-packet register writes.
    assign beat_cfg = sop ? reg_ctrl : active_cfg;

    always_comb begin
        i_val   = s_in_axis_tdata[ITEM_W-1:HALF_W];
        q_val   = s_in_axis_tdata[HALF_W-1:0];
        q_new   = beat_cfg.invert_en ? sat_neg16(q_val) : q_val;
        dat_new = beat_cfg.swap_iq ? {q_new, i_val} : {i_val, q_new};
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            m_out_axis_tdata      <= '0;
            m_out_axis_tkeep      <= 1'b0;
            m_out_axis_tlast      <= 1'b0;
            m_out_axis_tvalid     <= 1'b0;
            m_out_axis_ttimestamp <= '0;
            m_out_axis_thas_time  <= 1'b0;
            m_out_axis_tlength    <= '0;
            m_out_axis_teov       <= 1'b0;
            m_out_axis_teob       <= 1'b0;
            active_cfg            <= '0;
            sop                   <= 1'b1;
        end else begin
            if (in_acc) begin
                m_out_axis_tdata      <= dat_new;
                m_out_axis_tkeep      <= s_in_axis_tkeep;
                m_out_axis_tlast      <= s_in_axis_tlast;
                m_out_axis_tvalid     <= 1'b1;
                m_out_axis_ttimestamp <= s_in_axis_ttimestamp;
                m_out_axis_thas_time  <= s_in_axis_thas_time;
                m_out_axis_tlength    <= s_in_axis_tlength;
                m_out_axis_teov       <= s_in_axis_teov;
                m_out_axis_teob       <= s_in_axis_teob;
                sop                   <= s_in_axis_tlast;
                if (sop) begin
                    active_cfg <= reg_ctrl;
                end
            end else if (m_out_axis_tready) begin
                m_out_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_specinvert_core.sv
// Purpose  : self-checking bench for specinvert_core with a queue-based reference model.
// Latency  : checks 1-cycle beat latency and 1-cycle CtrlPort ack.
// Backpress: exercises always-ready, random 50% and fully stalled output.
module tb_specinvert_core;

    typedef struct {
        logic [31:0] dat;
        logic [63:0] ts;
        logic [20:0] sb;   // {has_time, length, eov, eob, keep, last}
        logic        last;
        int          cyc;
    } beat_t;

    logic        ce_clk = 1'b0;
    logic        ce_rst;
    logic        s_ctrlport_req_wr;
    logic        s_ctrlport_req_rd;
    logic [19:0] s_ctrlport_req_addr;
    logic [31:0] s_ctrlport_req_data;
    logic        s_ctrlport_resp_ack;
    logic [31:0] s_ctrlport_resp_data;
    logic [31:0] s_in_axis_tdata;
    logic        s_in_axis_tkeep;
    logic        s_in_axis_tlast;
    logic        s_in_axis_tvalid;
    logic        s_in_axis_tready;
    logic [63:0] s_in_axis_ttimestamp;
    logic        s_in_axis_thas_time;
    logic [15:0] s_in_axis_tlength;
    logic        s_in_axis_teov;
    logic        s_in_axis_teob;
    logic [31:0] m_out_axis_tdata;
    logic        m_out_axis_tkeep;
    logic        m_out_axis_tlast;
    logic        m_out_axis_tvalid;
    logic        m_out_axis_tready;
    logic [63:0] m_out_axis_ttimestamp;
    logic        m_out_axis_thas_time;
    logic [15:0] m_out_axis_tlength;
    logic        m_out_axis_teov;
    logic        m_out_axis_teob;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_mode = 0;      // 0: always ready, 1: random, 2: stalled
    logic [1:0]  mdl_ctrl = 2'b00;  // model of REG_CTRL
    logic [1:0]  mdl_cfg = 2'b00;   // config latched for the current input packet
    bit          mdl_sop = 1'b1;
    int unsigned mdl_cnt = 0;
    beat_t       exp_q[$];
    bit          front_seen = 1'b0;
    logic [31:0] last_out = '0;

    specinvert_core #(
        .COMPAT_NUM (32'h0001_0000),
        .ITEM_W     (32)
    ) dut (
        .ce_clk                (ce_clk),
        .ce_rst                (ce_rst),
        .s_ctrlport_req_wr     (s_ctrlport_req_wr),
        .s_ctrlport_req_rd     (s_ctrlport_req_rd),
        .s_ctrlport_req_addr   (s_ctrlport_req_addr),
        .s_ctrlport_req_data   (s_ctrlport_req_data),
        .s_ctrlport_resp_ack   (s_ctrlport_resp_ack),
        .s_ctrlport_resp_data  (s_ctrlport_resp_data),
        .s_in_axis_tdata       (s_in_axis_tdata),
        .s_in_axis_tkeep       (s_in_axis_tkeep),
        .s_in_axis_tlast       (s_in_axis_tlast),
        .s_in_axis_tvalid      (s_in_axis_tvalid),
        .s_in_axis_tready      (s_in_axis_tready),
        .s_in_axis_ttimestamp  (s_in_axis_ttimestamp),
        .s_in_axis_thas_time   (s_in_axis_thas_time),
        .s_in_axis_tlength     (s_in_axis_tlength),
        .s_in_axis_teov        (s_in_axis_teov),
        .s_in_axis_teob        (s_in_axis_teob),
        .m_out_axis_tdata      (m_out_axis_tdata),
        .m_out_axis_tkeep      (m_out_axis_tkeep),
        .m_out_axis_tlast      (m_out_axis_tlast),
        .m_out_axis_tvalid     (m_out_axis_tvalid),
        .m_out_axis_tready     (m_out_axis_tready),
        .m_out_axis_ttimestamp (m_out_axis_ttimestamp),
        .m_out_axis_thas_time  (m_out_axis_thas_time),
        .m_out_axis_tlength    (m_out_axis_tlength),
        .m_out_axis_teov       (m_out_axis_teov),
        .m_out_axis_teob       (m_out_axis_teob)
    );

    always #5 ce_clk = ~ce_clk;

    initial forever begin
        @(posedge ce_clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference transform, computed on signed integers.
    function automatic logic [31:0] ref_xform(input logic [31:0] d, input logic [1:0] cfg);
        int         ival;
        int         qval;
        logic [15:0] iv;
        logic [15:0] qv;
        ival = int'($signed(d[31:16]));
        qval = int'($signed(d[15:0]));
        if (cfg[0]) begin
            qval = -qval;
            if (qval > 32767) qval = 32767;
        end
        iv = ival[15:0];
        qv = qval[15:0];
        return cfg[1] ? {qv, iv} : {iv, qv};
    endfunction

    // Output ready generator; changes 2ns after the edge.
    initial forever begin
        @(posedge ce_clk);
        #2;
        case (rdy_mode)
            1:       m_out_axis_tready = 1'($urandom_range(0, 1));
            2:       m_out_axis_tready = 1'b0;
            default: m_out_axis_tready = 1'b1;
        endcase
    end

    // Input-side model: record expected output for each accepted beat.
    initial forever begin
        beat_t b;
        @(negedge ce_clk);
        if (!ce_rst && s_in_axis_tvalid && s_in_axis_tready) begin
            if (mdl_sop) mdl_cfg = mdl_ctrl;
            b.dat  = ref_xform(s_in_axis_tdata, mdl_cfg);
            b.ts   = s_in_axis_ttimestamp;
            b.sb   = {s_in_axis_thas_time, s_in_axis_tlength, s_in_axis_teov,
                      s_in_axis_teob, s_in_axis_tkeep, s_in_axis_tlast};
            b.last = s_in_axis_tlast;
            b.cyc  = cyc + 1;
            exp_q.push_back(b);
            mdl_sop = s_in_axis_tlast;
        end
    end

    // Output-side scoreboard: every valid cycle must show the queue front.
    initial forever begin
        beat_t b;
        @(negedge ce_clk);
        if (!ce_rst && m_out_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat_vld", m_out_axis_tvalid, 1'b0);
            end else begin
                b = exp_q[0];
                if (!front_seen) chk("beat_latency", cyc, b.cyc);
                chk("out_dat", m_out_axis_tdata, b.dat);
                chk("out_ts", m_out_axis_ttimestamp, b.ts);
                chk("out_sideband", {m_out_axis_thas_time, m_out_axis_tlength, m_out_axis_teov,
                                     m_out_axis_teob, m_out_axis_tkeep, m_out_axis_tlast}, b.sb);
                last_out   = m_out_axis_tdata;
                front_seen = 1'b1;
                if (m_out_axis_tready) begin
                    void'(exp_q.pop_front());
                    front_seen = 1'b0;
                    if (b.last) mdl_cnt++;
                end
            end
        end
    end

    // All driver tasks start and end 1ns after a rising edge.
    task automatic ctrl_write(input logic [19:0] a, input logic [31:0] d);
        s_ctrlport_req_wr   = 1'b1;
        s_ctrlport_req_addr = a;
        s_ctrlport_req_data = d;
        @(posedge ce_clk); #1;
        s_ctrlport_req_wr = 1'b0;
        chk("wr_ack", s_ctrlport_resp_ack, 1'b1);
        chk("wr_resp_dat", s_ctrlport_resp_data, 32'd0);
        if (a[7:0] == 8'h04) mdl_ctrl = d[1:0];
        else if (a[7:0] == 8'h08) mdl_cnt = 0;
    endtask

    task automatic ctrl_read(input string tag, input logic [19:0] a, input logic [31:0] exp);
        s_ctrlport_req_rd   = 1'b1;
        s_ctrlport_req_addr = a;
        @(posedge ce_clk); #1;
        s_ctrlport_req_rd = 1'b0;
        chk({tag, "_ack"}, s_ctrlport_resp_ack, 1'b1);
        chk({tag, "_dat"}, s_ctrlport_resp_data, exp);
        @(posedge ce_clk); #1;
        chk({tag, "_ack_drop"}, s_ctrlport_resp_ack, 1'b0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [63:0] ts,
                             input logic ht, input logic [15:0] len, input logic eov,
                             input logic eob, input logic keep);
        bit acc;
        int w;
        s_in_axis_tdata      = d;
        s_in_axis_tlast      = last;
        s_in_axis_ttimestamp = ts;
        s_in_axis_thas_time  = ht;
        s_in_axis_tlength    = len;
        s_in_axis_teov       = eov;
        s_in_axis_teob       = eob;
        s_in_axis_tkeep      = keep;
        s_in_axis_tvalid     = 1'b1;
        acc = 1'b0;
        w   = 0;
        while (!acc && w < 2000) begin
            @(negedge ce_clk);
            acc = s_in_axis_tready;
            @(posedge ce_clk); #1;
            w++;
        end
        if (!acc) chk("in_tready_timeout", s_in_axis_tready, 1'b1);
    endtask

    function automatic logic [31:0] rand_sample();
        logic [15:0] q;
        case ($urandom_range(0, 3))
            0:       q = 16'h8000;
            1:       q = 16'h0000;
            2:       q = 16'h7FFF;
            default: q = 16'($urandom);
        endcase
        return {16'($urandom), q};
    endfunction

    // wr_beat >= 0 issues a REG_CTRL write alongside that beat (always-ready mode only).
    task automatic send_pkt(input int n, input logic [31:0] dfix, input bit rnd,
                            input logic [63:0] ts0, input logic ht, input int wr_beat,
                            input logic [1:0] wr_val);
        for (int i = 0; i < n; i++) begin
            if (i == wr_beat) begin
                s_ctrlport_req_wr   = 1'b1;
                s_ctrlport_req_addr = 20'h00004;
                s_ctrlport_req_data = {30'd0, wr_val};
            end
            if (rnd)
                send_beat(rand_sample(), i == n - 1, {$urandom, $urandom}, 1'($urandom),
                          16'(n), 1'($urandom), i == n - 1, 1'($urandom));
            else
                send_beat(dfix, i == n - 1, ts0 + 64'(i), ht, 16'(n), 1'b0, i == n - 1, 1'b1);
            if (i == wr_beat) begin
                s_ctrlport_req_wr = 1'b0;
                chk("mid_wr_ack", s_ctrlport_resp_ack, 1'b1);
                mdl_ctrl = wr_val;
            end
        end
        s_in_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            @(posedge ce_clk); #1;
            w++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        ce_rst               = 1'b1;
        s_ctrlport_req_wr    = 1'b0;
        s_ctrlport_req_rd    = 1'b0;
        s_ctrlport_req_addr  = '0;
        s_ctrlport_req_data  = '0;
        s_in_axis_tdata      = '0;
        s_in_axis_tkeep      = 1'b0;
        s_in_axis_tlast      = 1'b0;
        s_in_axis_tvalid     = 1'b0;
        s_in_axis_ttimestamp = '0;
        s_in_axis_thas_time  = 1'b0;
        s_in_axis_tlength    = '0;
        s_in_axis_teov       = 1'b0;
        s_in_axis_teob       = 1'b0;
        m_out_axis_tready    = 1'b1;

        repeat (3) @(posedge ce_clk);
        #1;
        chk("rst_tvalid", m_out_axis_tvalid, 1'b0);
        chk("rst_tdata", m_out_axis_tdata, 32'd0);
        chk("rst_ts", m_out_axis_ttimestamp, 64'd0);
        chk("rst_sideband", {m_out_axis_thas_time, m_out_axis_tlength, m_out_axis_teov,
                             m_out_axis_teob, m_out_axis_tkeep, m_out_axis_tlast}, 21'd0);
        chk("rst_ack", s_ctrlport_resp_ack, 1'b0);
        chk("rst_resp_dat", s_ctrlport_resp_data, 32'd0);
        ce_rst = 1'b0;
        @(posedge ce_clk); #1;

        // Register map.
        ctrl_read("rd_compat", 20'h00000, 32'h0001_0000);
        ctrl_read("rd_ctrl", 20'h00004, 32'd0);
        ctrl_read("rd_cnt", 20'h00008, 32'd0);
        ctrl_read("rd_unmapped", 20'h00040, 32'd0);
        ctrl_write(20'h00040, 32'hFFFF_FFFF);
        ctrl_read("rd_ctrl_after_unmapped_wr", 20'h00004, 32'd0);

        // Invert an 8-beat packet with timestamps.
        ctrl_write(20'h00004, 32'h0000_0001);
        ctrl_read("rd_ctrl_alias", 20'hABC04, 32'd1);
        send_pkt(8, 32'h1234_5678, 1'b0, 64'h100, 1'b1, -1, 2'b00);
        drain();
        chk("inv_const", last_out, 32'h1234_A988);

        // Saturation and zero.
        send_pkt(1, 32'h0001_8000, 1'b0, 64'h0, 1'b0, -1, 2'b00);
        drain();
        chk("inv_sat", last_out, 32'h0001_7FFF);
        send_pkt(1, 32'h0005_0000, 1'b0, 64'h0, 1'b0, -1, 2'b00);
        drain();
        chk("inv_zero", last_out, 32'h0005_0000);

        // Invert plus swap.
        ctrl_write(20'h00004, 32'h0000_0003);
        send_pkt(1, 32'h1111_0002, 1'b0, 64'h7, 1'b1, -1, 2'b00);
        drain();
        chk("inv_swap", last_out, 32'hFFFE_1111);

        // Mid-packet write only affects the next packet.
        ctrl_write(20'h00004, 32'h0000_0000);
        send_pkt(6, 32'h1234_5678, 1'b0, 64'h200, 1'b1, 2, 2'b01);
        drain();
        chk("midpkt_unmodified", last_out, 32'h1234_5678);
        send_pkt(1, 32'h1234_5678, 1'b0, 64'h300, 1'b1, -1, 2'b00);
        drain();
        chk("next_pkt_inverted", last_out, 32'h1234_A988);

        // Combined wr+rd returns the pre-write value and still writes.
        s_ctrlport_req_wr   = 1'b1;
        s_ctrlport_req_rd   = 1'b1;
        s_ctrlport_req_addr = 20'h00004;
        s_ctrlport_req_data = 32'h0000_0002;
        @(posedge ce_clk); #1;
        s_ctrlport_req_wr = 1'b0;
        s_ctrlport_req_rd = 1'b0;
        chk("wrrd_ack", s_ctrlport_resp_ack, 1'b1);
        chk("wrrd_dat", s_ctrlport_resp_data, 32'd1);
        mdl_ctrl = 2'b10;
        @(posedge ce_clk); #1;
        chk("wrrd_single_ack", s_ctrlport_resp_ack, 1'b0);
        ctrl_read("rd_ctrl_after_wrrd", 20'h00004, 32'd2);
        ctrl_read("rd_cnt_directed", 20'h00008, 32'(mdl_cnt));

        // Random traffic with random backpressure.
        ctrl_write(20'h00008, 32'd0);
        rdy_mode = 1;
        for (int p = 0; p < 100; p++) begin
            if ($urandom_range(0, 3) == 0) ctrl_write(20'h00004, 32'($urandom_range(0, 3)));
            send_pkt($urandom_range(1, 8), 32'd0, 1'b1, 64'd0, 1'b0, -1, 2'b00);
        end
        rdy_mode = 0;
        @(posedge ce_clk); #1;
        drain();
        ctrl_read("rd_cnt_100", 20'h00008, 32'd100);

        // Clear coinciding with a tlast output handshake.
        send_pkt(1, 32'h0A0A_0B0B, 1'b0, 64'h0, 1'b0, -1, 2'b00);
        ctrl_write(20'h00008, 32'd0);
        drain();
        ctrl_read("rd_cnt_clear_wins", 20'h00008, 32'(mdl_cnt));
        ctrl_read("rd_cnt_clear_lit", 20'h00008, 32'd0);

        // Reset with a packet in flight and output stalled.
        ctrl_write(20'h00004, 32'h0000_0003);
        send_pkt(1, 32'h0101_0202, 1'b0, 64'h0, 1'b0, -1, 2'b00);
        drain();
        rdy_mode = 2;
        @(posedge ce_clk); #1;
        send_beat(32'h5555_6666, 1'b0, 64'h400, 1'b1, 16'd4, 1'b0, 1'b0, 1'b1);
        s_in_axis_tdata = 32'h7777_8888;
        @(posedge ce_clk); #1;
        chk("pre_rst_tvalid", m_out_axis_tvalid, 1'b1);
        ce_rst           = 1'b1;
        s_in_axis_tvalid = 1'b0;
        exp_q.delete();
        front_seen = 1'b0;
        mdl_sop    = 1'b1;
        mdl_ctrl   = 2'b00;
        mdl_cnt    = 0;
        #1;
        chk("async_rst_tvalid", m_out_axis_tvalid, 1'b0);
        chk("async_rst_tdata", m_out_axis_tdata, 32'd0);
        @(posedge ce_clk); #1;
        ce_rst   = 1'b0;
        rdy_mode = 0;
        @(posedge ce_clk); #1;
        ctrl_read("post_rst_ctrl", 20'h00004, 32'd0);
        ctrl_read("post_rst_cnt", 20'h00008, 32'd0);
        ctrl_write(20'h00004, 32'h0000_0001);
        send_pkt(2, 32'h1234_5678, 1'b0, 64'h500, 1'b1, -1, 2'b00);
        drain();
        chk("post_rst_sop_cfg", last_out, 32'h1234_A988);
        ctrl_read("post_rst_cnt_one", 20'h00008, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
